// File: rtl/sonic_v1_15_st_pkg.sv
// Shared helpers for the sonic v1.15 Avalon-ST adapters: width math and
// the ready-latency configuration check.
package sonic_v1_15_st_pkg;

    localparam int unsigned RL_MIN = 1;
    localparam int unsigned RL_MAX = 3;

    // Ceiling log2; clog2(1) is 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Legal adapter configuration: RL in range, power-of-two depth, room for in-flight beats.
    function automatic bit rl_cfg_ok(input int unsigned rl, input int unsigned depth);
        bit pow2;
        pow2 = (depth != 0) && ((depth & (depth - 1)) == 0);
        return (rl >= RL_MIN) && (rl <= RL_MAX) && pow2 && (depth >= rl + 2);
    endfunction

endpackage

// File: rtl/sonic_v1_15_st_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module sonic_v1_15_st_fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sonic_v1_15_jtag_master_timing_adt_rl.sv
// Ready-latency adapter (upstream RL=IN_READY_LATENCY -> downstream RL=0)
// for the JTAG master return path; an elastic FIFO absorbs in-flight beats.
module sonic_v1_15_jtag_master_timing_adt_rl
    import sonic_v1_15_st_pkg::*;
#(
    parameter int unsigned DATA_W           = 8,
    parameter int unsigned IN_READY_LATENCY = 1,
    parameter int unsigned DEPTH            = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              overflow
);

    localparam int unsigned PTR_W  = clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned THRESH = DEPTH - 1 - IN_READY_LATENCY;

    generate
        if (!rl_cfg_ok(IN_READY_LATENCY, DEPTH)) begin : g_cfg_err
            $error("sonic_v1_15_jtag_master_timing_adt_rl: illegal IN_READY_LATENCY/DEPTH combination");
        end
    endgenerate

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_in_ready;
    logic              r_overflow;

    logic              w_out_valid;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [CNT_W-1:0]  w_count_next;
    logic [DATA_W-1:0] w_rd_data;

    // A full FIFO still takes a beat when the head leaves in the same cycle.
    assign w_out_valid  = (r_count != '0);
    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_pop        = w_out_valid & out_ready;
    assign w_push       = in_valid & (~w_full | w_pop);
    assign w_drop       = in_valid & w_full & ~w_pop;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // in_ready looks only at count_next, so it leaves room for RL in-flight beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next <= CNT_W'(THRESH));
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sonic_v1_15_st_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_rd_data;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_sonic_v1_15_jtag_master_timing_adt_rl.sv
// Scoreboard bench for the RL adapter: a queue model of the FIFO is checked
// against the selected DUT (DEPTH=4/RL=1 or DEPTH=8/RL=3) every cycle.
module tb_sonic_v1_15_jtag_master_timing_adt_rl;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       ir4, ov4, ovf4;
    logic [7:0] od4;
    logic       ir8, ov8, ovf8;
    logic [7:0] od8;

    sonic_v1_15_jtag_master_timing_adt_rl #(
        .DATA_W(8), .IN_READY_LATENCY(1), .DEPTH(4)
    ) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir4), .out_valid(ov4), .out_data(od4),
        .out_ready(out_ready), .overflow(ovf4)
    );

    sonic_v1_15_jtag_master_timing_adt_rl #(
        .DATA_W(8), .IN_READY_LATENCY(3), .DEPTH(8)
    ) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir8), .out_valid(ov8), .out_data(od8),
        .out_ready(out_ready), .overflow(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit         sel;
    logic       obs_ir, obs_valid, obs_ovf;
    logic [7:0] obs_data;
    assign obs_ir    = sel ? ir8  : ir4;
    assign obs_valid = sel ? ov8  : ov4;
    assign obs_ovf   = sel ? ovf8 : ovf4;
    assign obs_data  = sel ? od8  : od4;

    int         checks;
    int         failures;
    logic [7:0] q[$];
    bit         m_ovf;
    bit         m_ir;
    int         depth_m;
    int         rl_m;
    bit         hist[4];
    int         sent;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge: compare outputs, drive inputs, advance the model one edge.
    task automatic tick(input bit v, input logic [7:0] d, input bit ordy);
        bit pop;
        bit full;
        bit push;
        check("out_valid", obs_valid, q.size() != 0);
        if (q.size() != 0) check("out_data", obs_data, q[0]);
        check("in_ready", obs_ir, m_ir);
        check("overflow", obs_ovf, m_ovf);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        pop  = (q.size() != 0) && ordy;
        full = (q.size() >= depth_m);
        if (pop) void'(q.pop_front());
        push = v && (!full || pop);
        if (push) q.push_back(d);
        if (v && !push) m_ovf = 1'b1;
        m_ir = (q.size() <= depth_m - 1 - rl_m);
        @(negedge clk);
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = obs_ir;
    endtask

    // Upstream that only sends when in_ready was high RL cycles earlier.
    task automatic send(input int n, input logic [7:0] base, input bit ordy,
                        input int budget, output int n_sent);
        n_sent = 0;
        for (int c = 0; c < budget && n_sent < n; c++) begin
            if (hist[rl_m]) begin
                tick(1'b1, base + 8'(n_sent), ordy);
                n_sent++;
            end else begin
                tick(1'b0, 8'h00, ordy);
            end
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int c = 0; c < n; c++) tick(1'b0, 8'h00, ordy);
    endtask

    // Async reset asserted between edges; outputs must clear before the next edge.
    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_out_valid", obs_valid, 1'b0);
        check("rst_in_ready", obs_ir, 1'b0);
        check("rst_overflow", obs_ovf, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_ir  = 1'b0;
        for (int i = 0; i < 4; i++) hist[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        sel       = 1'b0;
        depth_m   = 4;
        rl_m      = 1;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Streaming 0x01..0x10 with the sink always ready.
        send(16, 8'h01, 1'b1, 40, sent);
        check("stream_sent", sent, 16);
        idle(3, 1'b1);

        // Backpressure: A0..A3 fit, in_ready stops further beats.
        send(6, 8'hA0, 1'b0, 10, sent);
        check("rl1_fill_sent", sent, 4);
        // Full with simultaneous pop accepts 0x55; full without pop drops 0x77.
        tick(1'b1, 8'h55, 1'b1);
        tick(1'b1, 8'h77, 1'b0);
        idle(2, 1'b0);
        idle(6, 1'b1);

        // Reset mid-drain with three entries left.
        send(6, 8'hB0, 1'b0, 10, sent);
        check("refill_sent", sent, 4);
        tick(1'b0, 8'h00, 1'b1);
        do_reset();
        send(4, 8'hC0, 1'b1, 20, sent);
        check("post_rst_sent", sent, 4);
        idle(3, 1'b1);

        // RL=3, DEPTH=8: burst into a stalled sink fills exactly 8 entries.
        sel     = 1'b1;
        depth_m = 8;
        rl_m    = 3;
        do_reset();
        send(12, 8'hD0, 1'b0, 20, sent);
        check("rl3_sent", sent, 8);
        idle(3, 1'b0);
        idle(10, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
